// File: rtl/s2mm_ring_sequencer.sv
// S2MM command sequencer: fixed-size write commands into a circular DDR buffer, tracks status and completed pointer.
// Optional S2MM_SEQ_ONESHOT_EN: stop after the last ring block until enable toggles 0->1.
module s2mm_ring_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] RING_BYTES = 32'h0010_0000,
  parameter logic [22:0] BTT        = 23'h00_1000,
  parameter int          MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [71:0] cmd_tdata,
  output logic        cmd_tvalid,
  input  logic        cmd_tready,
  input  logic [7:0]  sts_tdata,
  input  logic        sts_tvalid,
  output logic        sts_tready,
  output logic [31:0] wr_ptr,
  output logic [31:0] blk_count,
  output logic [3:0]  outstanding,
  output logic        busy,
  output logic        err
);

  localparam logic [31:0] RING_END  = BASE_ADDR + RING_BYTES;
  localparam logic [31:0] LAST_BLK  = RING_END - {9'd0, BTT};
  localparam logic [3:0]  MAX_OUT_C = 4'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

  state_t      state, state_d;
  logic [31:0] next_addr;
  logic [3:0]  next_tag, exp_tag;
  logic [3:0]  out_d;
  logic        cmd_fire, sts_fire, sts_good, sts_bad;
  logic        can_issue, issue_start, halt_exit;
  logic        os_done, enable_q, en_rise;

  function automatic logic [31:0] ring_inc(input logic [31:0] a);
    logic [31:0] s;
    s = a + {9'd0, BTT};
    return (s == RING_END) ? BASE_ADDR : s;
  endfunction

  assign cmd_fire = cmd_tvalid & cmd_tready;
  assign sts_fire = sts_tvalid & sts_tready;
  // A status with nothing in flight is spurious and therefore never good.
  assign sts_good = sts_tdata[7] && (sts_tdata[6:4] == 3'b000) &&
                    (sts_tdata[3:0] == exp_tag) && (outstanding != 4'd0);
  assign sts_bad  = sts_fire & ~sts_good;
  assign en_rise  = enable & ~enable_q;
  assign busy     = (outstanding != 4'd0) | cmd_tvalid;

`ifdef S2MM_SEQ_ONESHOT_EN
  assign can_issue = enable & ~err & (outstanding < MAX_OUT_C) & ~os_done;
`else
  assign can_issue = enable & ~err & (outstanding < MAX_OUT_C);
`endif

  always_comb begin
    state_d     = state;
    issue_start = 1'b0;
    halt_exit   = 1'b0;
    case (state)
      IDLE:    if (can_issue) begin
                 state_d     = ISSUE;
                 issue_start = 1'b1;
               end
      ISSUE:   if (cmd_fire) state_d = IDLE;
      HALT:    if (!enable && outstanding == 4'd0 && !cmd_tvalid) begin
                 state_d   = IDLE;
                 halt_exit = 1'b1;
               end
      default: state_d = IDLE;
    endcase
    if (sts_bad) begin
      state_d     = HALT;
      issue_start = 1'b0;
      halt_exit   = 1'b0;
    end
  end

  always_comb begin
    out_d = outstanding;
    case ({cmd_fire, sts_fire})
      2'b10:   out_d = outstanding + 4'd1;
      2'b01:   if (outstanding != 4'd0) out_d = outstanding - 4'd1;
      default: out_d = outstanding;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_tvalid  <= 1'b0;
      cmd_tdata   <= '0;
      sts_tready  <= 1'b0;
      wr_ptr      <= BASE_ADDR;
      blk_count   <= '0;
      outstanding <= '0;
      err         <= 1'b0;
      next_addr   <= BASE_ADDR;
      next_tag    <= '0;
      exp_tag     <= '0;
      os_done     <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state       <= state_d;
      sts_tready  <= 1'b1;
      enable_q    <= enable;
      outstanding <= out_d;

      // tdata is captured once on entry to ISSUE and held until the handshake.
      if (issue_start) begin
        cmd_tvalid <= 1'b1;
        cmd_tdata  <= {4'b0, next_tag, next_addr, 8'h00, 1'b1, BTT};
      end else if (cmd_fire) begin
        cmd_tvalid <= 1'b0;
      end

      if (cmd_fire) begin
        next_addr <= ring_inc(next_addr);
        next_tag  <= next_tag + 4'd1;
        if (cmd_tdata[63:32] == LAST_BLK) os_done <= 1'b1;
      end

      if (sts_fire) begin
        if (sts_good) begin
          exp_tag   <= exp_tag + 4'd1;
          blk_count <= blk_count + 32'd1;
          wr_ptr    <= ring_inc(wr_ptr);
        end else begin
          err <= 1'b1;
        end
      end

      if (os_done && en_rise) begin
        os_done   <= 1'b0;
        next_addr <= BASE_ADDR;
      end

      // Leaving HALT resynchronises tags; nothing is in flight at this point.
      if (halt_exit) begin
        err       <= 1'b0;
        next_addr <= BASE_ADDR;
        wr_ptr    <= BASE_ADDR;
        next_tag  <= '0;
        exp_tag   <= '0;
        os_done   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s2mm_ring_sequencer.sv
// Scoreboard bench for s2mm_ring_sequencer (3-block ring, MAX_OUT=2).
// With S2MM_SEQ_ONESHOT_EN defined it runs the capture-once scenario instead.
module tb_s2mm_ring_sequencer;

  localparam logic [31:0] RING = 32'h3000;

  typedef struct { int due; logic [7:0] data; } sts_t;
  typedef struct { logic [71:0] w; logic [71:0] m; } exp_t;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, cmd_tready = 1'b0;
  logic        sts_tvalid = 1'b0;
  logic [7:0]  sts_tdata = 8'h00;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid, sts_tready, busy, err;
  logic [31:0] wr_ptr, blk_count;
  logic [3:0]  outstanding;

  int   checks = 0, errors = 0, cyc = 0, n_cmds = 0;
  bit   auto_sts = 1'b0;
  sts_t pend[$];
  exp_t exp_q[$];

  s2mm_ring_sequencer #(.RING_BYTES(RING), .MAX_OUT(2)) dut (
    .clk(clk), .reset(rst), .enable(enable),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
    .wr_ptr(wr_ptr), .blk_count(blk_count), .outstanding(outstanding),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] cmdw(input logic [3:0] tag, input logic [31:0] a);
    return {4'b0, tag, a, 8'h00, 1'b1, 23'h00_1000};
  endfunction

  task automatic push_cmd(input logic [3:0] tag, input logic [31:0] a, input bit any_tag);
    exp_t e;
    e.w = cmdw(tag, a);
    e.m = '1;
    if (any_tag) e.m[67:64] = 4'h0;
    exp_q.push_back(e);
  endtask

  task automatic push_sts(input logic [7:0] d);
    sts_t s;
    s.due  = cyc;
    s.data = d;
    pend.push_back(s);
  endtask

  // Command monitor: each accepted command is popped from the scoreboard.
  always @(negedge clk) begin
    if (cmd_tvalid && cmd_tready) begin
      exp_t e;
      sts_t s;
      n_cmds++;
      chk("cmd_expected", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cmd_word", cmd_tdata & e.m, e.w & e.m);
      end
      if (auto_sts) begin
        s.due  = cyc + 20;
        s.data = {4'h8, cmd_tdata[67:64]};
        pend.push_back(s);
      end
    end
  end

  // Status driver: one beat per cycle once due.
  always @(posedge clk) begin
    #1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      sts_tvalid = 1'b1;
      sts_tdata  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      sts_tvalid = 1'b0;
      sts_tdata  = 8'h00;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cmds(input int target);
    int k = 0;
    while (n_cmds < target && k < 400) begin
      @(posedge clk); #1; k++;
    end
    if (n_cmds < target) chk("cmd_timeout", 72'(n_cmds), 72'(target));
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while ((busy || pend.size() != 0 || sts_tvalid) && k < 400);
    chk("idle_timeout", 72'(busy), 72'd0);
    cyc_wait(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(1);
  endtask

  initial begin
    int base, viol;
    logic [71:0] cap;

    #12;
    chk("rst_tvalid", 72'(cmd_tvalid), 72'd0);
    chk("rst_tready", 72'(sts_tready), 72'd0);
    chk("rst_wr_ptr", 72'(wr_ptr), 72'h0);
    chk("rst_blk", 72'(blk_count), 72'd0);
    chk("rst_out", 72'(outstanding), 72'd0);
    chk("rst_err", 72'(err), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    do_reset();
    chk("sts_tready_up", 72'(sts_tready), 72'd1);

`ifdef S2MM_SEQ_ONESHOT_EN
    auto_sts = 1'b1;
    cmd_tready = 1'b1;
    push_cmd(4'd0, 32'h0, 1'b0);
    push_cmd(4'd1, 32'h1000, 1'b0);
    push_cmd(4'd2, 32'h2000, 1'b0);
    enable = 1'b1;
    wait_cmds(3);
    cyc_wait(80);
    chk("os_count", 72'(n_cmds), 72'd3);
    chk("os_no_tvalid", 72'(cmd_tvalid), 72'd0);
    enable = 1'b0;
    wait_idle();
    chk("os_blk", 72'(blk_count), 72'd3);
    chk("os_wr_ptr", 72'(wr_ptr), 72'h0);
    push_cmd(4'd3, 32'h0, 1'b0);
    enable = 1'b1;
    wait_cmds(4);
    enable = 1'b0;
    wait_idle();
    chk("os_restart_cnt", 72'(n_cmds), 72'd4);
    chk("os_restart_blk", 72'(blk_count), 72'd4);
`else
    // Continuous run with wrap: 0,1000,2000 then 0,1000.
    auto_sts = 1'b1;
    cmd_tready = 1'b1;
    push_cmd(4'd0, 32'h0, 1'b0);
    push_cmd(4'd1, 32'h1000, 1'b0);
    push_cmd(4'd2, 32'h2000, 1'b0);
    enable = 1'b1;
    wait_cmds(3);
    enable = 1'b0;
    wait_idle();
    chk("t1_blk", 72'(blk_count), 72'd3);
    chk("t1_wr_ptr_wrap", 72'(wr_ptr), 72'h0);
    push_cmd(4'd3, 32'h0, 1'b0);
    push_cmd(4'd4, 32'h1000, 1'b0);
    enable = 1'b1;
    wait_cmds(5);
    enable = 1'b0;
    wait_idle();
    chk("t2_blk", 72'(blk_count), 72'd5);
    chk("t2_wr_ptr", 72'(wr_ptr), 72'h2000);
    chk("t2_out", 72'(outstanding), 72'd0);

    // Outstanding cap with status withheld.
    auto_sts = 1'b0;
    base = n_cmds;
    push_cmd(4'd5, 32'h2000, 1'b0);
    push_cmd(4'd6, 32'h0, 1'b0);
    enable = 1'b1;
    wait_cmds(base + 2);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_tvalid) viol++;
      cyc_wait(1);
    end
    chk("cap_tvalid_low", 72'(viol), 72'd0);
    chk("cap_cmds", 72'(n_cmds - base), 72'd2);
    chk("cap_out", 72'(outstanding), 72'd2);
    chk("cap_busy", 72'(busy), 72'd1);
    enable = 1'b0;
    push_sts(8'h85);
    push_sts(8'h86);
    wait_idle();
    chk("cap_blk", 72'(blk_count), 72'd7);
    chk("cap_wr_ptr", 72'(wr_ptr), 72'h1000);

    // Back-pressure: tvalid/tdata held while enable drops.
    base = n_cmds;
    push_cmd(4'd7, 32'h1000, 1'b0);
    cmd_tready = 1'b0;
    enable = 1'b1;
    viol = 0;
    while (!cmd_tvalid && viol < 20) begin cyc_wait(1); viol++; end
    cap = cmd_tdata;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) enable = 1'b0;
      if (!cmd_tvalid || cmd_tdata !== cap) viol++;
      cyc_wait(1);
    end
    chk("hold_stable", 72'(viol), 72'd0);
    chk("hold_word", cap, cmdw(4'd7, 32'h1000));
    auto_sts = 1'b1;
    cmd_tready = 1'b1;
    wait_idle();
    cyc_wait(10);
    chk("hold_one_cmd", 72'(n_cmds - base), 72'd1);
    chk("hold_blk", 72'(blk_count), 72'd8);
    chk("hold_wr_ptr", 72'(wr_ptr), 72'h2000);

    // Error on second block, then recovery.
    do_reset();
    auto_sts = 1'b0;
    base = n_cmds;
    push_cmd(4'd0, 32'h0, 1'b0);
    push_cmd(4'd1, 32'h1000, 1'b0);
    enable = 1'b1;
    wait_cmds(base + 2);
    cyc_wait(3);
    push_sts(8'h80);
    push_sts(8'h41);
    cyc_wait(12);
    chk("e_err", 72'(err), 72'd1);
    chk("e_blk", 72'(blk_count), 72'd1);
    chk("e_wr_ptr", 72'(wr_ptr), 72'h1000);
    chk("e_out", 72'(outstanding), 72'd0);
    chk("e_no_cmd", 72'(n_cmds - base), 72'd2);
    enable = 1'b0;
    cyc_wait(3);
    chk("e_err_clr", 72'(err), 72'd0);
    chk("e_wr_ptr_base", 72'(wr_ptr), 72'h0);
    push_cmd(4'd0, 32'h0, 1'b1);
    auto_sts = 1'b1;
    enable = 1'b1;
    wait_cmds(base + 3);
    enable = 1'b0;
    wait_idle();
    chk("e_rec_blk", 72'(blk_count), 72'd2);
    chk("e_rec_wr_ptr", 72'(wr_ptr), 72'h1000);

    // Spurious status with nothing in flight.
    auto_sts = 1'b0;
    push_sts(8'h81);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      cyc_wait(1);
      if (err) viol = 1;
    end
    chk("spur_err_seen", 72'(viol), 72'd1);
    chk("spur_out_sat", 72'(outstanding), 72'd0);
    chk("spur_err_clr", 72'(err), 72'd0);

    // Async reset drops a pending command at once.
    cmd_tready = 1'b0;
    enable = 1'b1;
    viol = 0;
    while (!cmd_tvalid && viol < 20) begin cyc_wait(1); viol++; end
    chk("pre_rst_tvalid", 72'(cmd_tvalid), 72'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tvalid", 72'(cmd_tvalid), 72'd0);
    chk("async_rst_out", 72'(outstanding), 72'd0);
    enable = 1'b0;
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(2);
`endif

    chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
